// File: rtl/bch_pkg.sv
// Shared types and GF(2^m) helpers for the double-error-correcting BCH decoder.
package bch_pkg;

   localparam int unsigned GF_W = 16;
   typedef logic [GF_W-1:0] gf_wide_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYND,
      ST_KEY,
      ST_CHIEN,
      ST_DONE
   } state_t;

   // Number of locator roots the syndromes predict; CLS_FAIL has no valid pattern.
   typedef enum logic [1:0] {
      CLS_NONE = 2'd0,
      CLS_ONE  = 2'd1,
      CLS_TWO  = 2'd2,
      CLS_FAIL = 2'd3
   } err_class_t;

   // Shift-and-add multiply reduced by poly (poly carries the x^m term).
   function automatic gf_wide_t gf_mul(input gf_wide_t a, input gf_wide_t b,
                                       input int unsigned m, input gf_wide_t poly);
      gf_wide_t acc;
      gf_wide_t x;
      gf_wide_t top;
      acc = '0;
      x   = a;
      top = gf_wide_t'(1) << m;
      for (int unsigned i = 0; i < GF_W - 1; i++) begin
         if (i < m) begin
            if (((b >> i) & gf_wide_t'(1)) != '0) acc ^= x;
            x = x << 1;
            if ((x & top) != '0) x ^= poly;
         end
      end
      return acc;
   endfunction

   function automatic gf_wide_t gf_alpha_pow(input int unsigned k, input int unsigned m,
                                             input gf_wide_t poly);
      gf_wide_t x;
      x = gf_wide_t'(1);
      for (int unsigned i = 0; i < k; i++) x = gf_mul(x, gf_wide_t'(2), m, poly);
      return x;
   endfunction

endpackage

// File: rtl/bch_dec_t2_gf_mult.sv
// Combinational M-bit GF(2^M) multiplier.
module gf_mult
   import bch_pkg::*;
#(
   parameter int unsigned M         = 4,
   parameter int unsigned PRIM_POLY = 'h13
) (
   input  logic [M-1:0] a,
   input  logic [M-1:0] b,
   output logic [M-1:0] p_c
);

   localparam gf_wide_t POLY = gf_wide_t'(PRIM_POLY);

   always_comb p_c = M'(gf_mul(gf_wide_t'(a), gf_wide_t'(b), M, POLY));

endmodule

// File: rtl/bch_dec_t2.sv
// Double-error-correcting binary BCH decoder: serial syndromes, division-free
// locator, fixed-length Chien search, one word in flight.
module bch_dec_t2
   import bch_pkg::*;
#(
   parameter  int unsigned M         = 4,
   parameter  int unsigned PRIM_POLY = 'h13,
   parameter  int unsigned K         = 7,
   localparam int unsigned N         = (1 << M) - 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic [K-1:0] out_msg,
   output logic [1:0]   out_nerr,
   output logic         out_fail
);

   localparam gf_wide_t     POLY   = gf_wide_t'(PRIM_POLY);
   localparam gf_wide_t     ALPHA1 = gf_alpha_pow(1, M, POLY);
   localparam gf_wide_t     ALPHA2 = gf_alpha_pow(2, M, POLY);
   localparam gf_wide_t     ALPHA3 = gf_alpha_pow(3, M, POLY);
   localparam logic [M-1:0] LAST   = M'(N - 1);

   state_t       state, state_nxt;
   err_class_t   cls, cls_key_c;
   logic [M-1:0] cnt;
   logic [N-1:0] word, orig;
   logic [M-1:0] s1, s3, a, b, c;
   logic [1:0]   nroot, nroot_nxt_c;
   logic [M-1:0] s1_sq_c, s1_cu_c, c_key_c, s1_hor_c, s3_hor_c, a_step_c, b_step_c;
   logic         r_bit_c, hit_c, fail_c;
   logic [N-1:0] word_flip_c;

   gf_mult #(.M(M), .PRIM_POLY(PRIM_POLY)) u_sq (.a(s1),      .b(s1), .p_c(s1_sq_c));
   gf_mult #(.M(M), .PRIM_POLY(PRIM_POLY)) u_cu (.a(s1_sq_c), .b(s1), .p_c(s1_cu_c));

   // Horner syndrome update, highest-order received bit first.
   assign r_bit_c  = word[cnt];
   assign s1_hor_c = M'(gf_mul(gf_wide_t'(s1), ALPHA1, M, POLY)) ^ M'(r_bit_c);
   assign s3_hor_c = M'(gf_mul(gf_wide_t'(s3), ALPHA3, M, POLY)) ^ M'(r_bit_c);
   assign c_key_c  = s3 ^ s1_cu_c;

   always_comb begin
      cls_key_c = CLS_TWO;
      if (s1 == '0)          cls_key_c = (s3 == '0) ? CLS_NONE : CLS_FAIL;
      else if (c_key_c == '0) cls_key_c = CLS_ONE;
   end

   // Locator S1 + S1^2 x + C x^2 scaled by alpha^(2i); a zero sum marks position i.
   assign a_step_c    = M'(gf_mul(gf_wide_t'(a), ALPHA2, M, POLY));
   assign b_step_c    = M'(gf_mul(gf_wide_t'(b), ALPHA1, M, POLY));
   assign hit_c       = ((a ^ b ^ c) == '0) && ((a | b) != '0);
   assign word_flip_c = word ^ (N'(hit_c) << cnt);
   assign nroot_nxt_c = (hit_c && (nroot != 2'd3)) ? nroot + 2'd1 : nroot;
   assign fail_c      = (cls == CLS_FAIL) || (nroot_nxt_c != 2'(cls));

   assign out_msg = out_data[N-1:N-K];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (in_valid) state_nxt = ST_SYND;
         ST_SYND:  if (cnt == '0) state_nxt = ST_KEY;
         ST_KEY:   state_nxt = ST_CHIEN;
         ST_CHIEN: if (cnt == LAST) state_nxt = ST_DONE;
         ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_nerr  <= '0;
         out_fail  <= 1'b0;
         cnt       <= '0;
         word      <= '0;
         orig      <= '0;
         s1        <= '0;
         s3        <= '0;
         a         <= '0;
         b         <= '0;
         c         <= '0;
         nroot     <= '0;
         cls       <= CLS_NONE;
      end else begin
         in_ready  <= (state_nxt == ST_IDLE);
         out_valid <= (state_nxt == ST_DONE);
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  word <= in_data;
                  orig <= in_data;
                  s1   <= '0;
                  s3   <= '0;
                  cnt  <= LAST;
               end
            end
            ST_SYND: begin
               s1  <= s1_hor_c;
               s3  <= s3_hor_c;
               cnt <= cnt - M'(1);
            end
            ST_KEY: begin
               a     <= s1;
               b     <= s1_sq_c;
               c     <= c_key_c;
               cls   <= cls_key_c;
               nroot <= '0;
               cnt   <= '0;
            end
            ST_CHIEN: begin
               a     <= a_step_c;
               b     <= b_step_c;
               word  <= word_flip_c;
               nroot <= nroot_nxt_c;
               cnt   <= cnt + M'(1);
               if (cnt == LAST) begin
                  out_data <= fail_c ? orig : word_flip_c;
                  out_nerr <= fail_c ? 2'd3 : nroot_nxt_c;
                  out_fail <= fail_c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bch_dec_t2.sv
// Randomised and swept bench for bch_dec_t2 at M=4 and M=5 against a brute-force syndrome-matching decoder.
`timescale 1ns/1ps
module tb_bch_dec_t2;

   localparam int M0 = 4, N0 = 15, K0 = 7,  P0 = 'h13;
   localparam int M1 = 5, N1 = 31, K1 = 21, P1 = 'h25;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          iv0, ir0, ov0, ordy0, f0;
   logic [N0-1:0] id0, od0;
   logic [K0-1:0] om0;
   logic [1:0]    ne0;
   logic          iv1, ir1, ov1, ordy1, f1;
   logic [N1-1:0] id1, od1;
   logic [K1-1:0] om1;
   logic [1:0]    ne1;

   bch_dec_t2 #(.M(M0), .PRIM_POLY(P0), .K(K0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
      .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .out_msg(om0),
      .out_nerr(ne0), .out_fail(f0));

   bch_dec_t2 #(.M(M1), .PRIM_POLY(P1), .K(K1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
      .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .out_msg(om1),
      .out_nerr(ne1), .out_fail(f1));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: bounded-distance decode by matching syndromes of all weight<=2 patterns.
   function automatic void ref_decode(input int m, input int poly, input logic [63:0] r,
                                      output logic [63:0] d, output int ne, output bit fl);
      int ex[64];
      int n, x, s1, s3;
      bit done;
      n = (1 << m) - 1;
      x = 1;
      for (int i = 0; i < n; i++) begin
         ex[i] = x;
         x = x << 1;
         if ((x & (1 << m)) != 0) x ^= poly;
      end
      s1 = 0; s3 = 0;
      for (int i = 0; i < n; i++)
         if (r[i]) begin s1 ^= ex[i]; s3 ^= ex[(3*i) % n]; end
      d = r; ne = 3; fl = 1'b1; done = 1'b0;
      if (s1 == 0 && s3 == 0) begin ne = 0; fl = 1'b0; done = 1'b1; end
      for (int j = 0; j < n; j++)
         if (!done && ex[j] == s1 && ex[(3*j) % n] == s3) begin
            d[j] = ~d[j]; ne = 1; fl = 1'b0; done = 1'b1;
         end
      for (int j = 0; j < n; j++)
         for (int k = j + 1; k < n; k++)
            if (!done && (ex[j] ^ ex[k]) == s1 && (ex[(3*j) % n] ^ ex[(3*k) % n]) == s3) begin
               d[j] = ~d[j]; d[k] = ~d[k]; ne = 2; fl = 1'b0; done = 1'b1;
            end
   endfunction

   // Generator = the unique degree-2m polynomial with zero syndromes.
   function automatic logic [63:0] find_gen(input int m, input int poly);
      logic [63:0] g, cand, d;
      int ne;
      bit fl;
      g = '0;
      for (int i = 1; i < (1 << (2*m)); i += 2) begin
         cand = (64'd1 << (2*m)) | 64'(i);
         ref_decode(m, poly, cand, d, ne, fl);
         if (ne == 0 && g == '0) g = cand;
      end
      return g;
   endfunction

   function automatic logic [63:0] clmul(input logic [63:0] a, input logic [63:0] b);
      logic [63:0] acc;
      acc = '0;
      for (int i = 0; i < 64; i++) if (b[i]) acc ^= a << i;
      return acc;
   endfunction

   function automatic logic [63:0] rand_err(input int n, input int w);
      logic [63:0] e;
      int placed, p;
      e = '0; placed = 0;
      while (placed < w) begin
         p = int'($urandom_range(n - 1, 0));
         if (!e[p]) begin e[p] = 1'b1; placed++; end
      end
      return e;
   endfunction

   function automatic logic ready_of(input int sel); return (sel == 0) ? ir0 : ir1; endfunction
   function automatic logic valid_of(input int sel); return (sel == 0) ? ov0 : ov1; endfunction

   task automatic set_in(input int sel, input logic v, input logic [63:0] w);
      if (sel == 0) begin iv0 = v; id0 = w[N0-1:0]; end
      else          begin iv1 = v; id1 = w[N1-1:0]; end
   endtask

   task automatic run_word(input int sel, input logic [63:0] w, output logic [63:0] d,
                           output logic [63:0] msg, output logic [1:0] ne, output logic fl,
                           output int lat);
      int guard;
      @(negedge clk);
      set_in(sel, 1'b1, w);
      guard = 0;
      while (!ready_of(sel) && guard < 200) begin @(negedge clk); guard++; end
      if (guard >= 200) chk("in_ready_timeout", 64'(ready_of(sel)), 64'd1);
      @(negedge clk);
      set_in(sel, 1'b0, '0);
      lat = 1;
      while (!valid_of(sel) && lat < 300) begin @(negedge clk); lat++; end
      if (lat >= 300) chk("out_valid_timeout", 64'(valid_of(sel)), 64'd1);
      if (sel == 0) begin d = 64'(od0); msg = 64'(om0); ne = ne0; fl = f0; ordy0 = 1'b1; end
      else          begin d = 64'(od1); msg = 64'(om1); ne = ne1; fl = f1; ordy1 = 1'b1; end
      @(negedge clk);
      ordy0 = 1'b0; ordy1 = 1'b0;
   endtask

   task automatic check_word(input int sel, input string tag, input logic [63:0] w,
                             output logic [63:0] d, output logic [1:0] ne);
      logic [63:0] msg, ed;
      logic        fl;
      int          en, lat, m, poly, n, k;
      bit          ef;
      m    = (sel == 0) ? M0 : M1;
      poly = (sel == 0) ? P0 : P1;
      n    = (sel == 0) ? N0 : N1;
      k    = (sel == 0) ? K0 : K1;
      run_word(sel, w, d, msg, ne, fl, lat);
      ref_decode(m, poly, w, ed, en, ef);
      chk({tag, "_data"}, d, ed);
      chk({tag, "_msg"},  msg, ed >> (n - k));
      chk({tag, "_nerr"}, 64'(ne), 64'(en));
      chk({tag, "_fail"}, 64'(fl), 64'(ef));
      chk({tag, "_lat"},  64'(lat), 64'(2*n + 2));
   endtask

   initial begin
      logic [63:0] g0, g1, cw, w, d, msg;
      logic [1:0]  ne;
      int          guard;
      iv0 = 1'b0; id0 = '0; ordy0 = 1'b0;
      iv1 = 1'b0; id1 = '0; ordy1 = 1'b0;

      #12;
      chk("rst_in_ready0", 64'(ir0), 64'd1);
      chk("rst_valid0",    64'(ov0), 64'd0);
      chk("rst_data0",     64'(od0), 64'd0);
      chk("rst_nerr0",     64'(ne0), 64'd0);
      chk("rst_fail0",     64'(f0),  64'd0);
      chk("rst_in_ready1", 64'(ir1), 64'd1);
      chk("rst_valid1",    64'(ov1), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      g0 = find_gen(M0, P0);
      g1 = find_gen(M1, P1);

      // Directed words around the (15,7) generator polynomial.
      check_word(0, "cw", 64'h01D1, d, ne);
      chk("cw_exact", d, 64'h01D1);
      chk("cw_nerr0", 64'(ne), 64'd0);
      check_word(0, "one", 64'h01D9, d, ne);
      chk("one_exact", d, 64'h01D1);
      chk("one_nerr1", 64'(ne), 64'd1);
      check_word(0, "two", 64'h41D0, d, ne);
      chk("two_exact", d, 64'h01D1);
      chk("two_nerr2", 64'(ne), 64'd2);

      for (int i = 0; i < N0; i++) begin
         check_word(0, "s4", 64'h01D1 ^ (64'd1 << i), d, ne);
         chk("s4_cw", d, 64'h01D1);
      end
      for (int i = 0; i < N0; i++)
         for (int j = i + 1; j < N0; j++) begin
            check_word(0, "d4", 64'h01D1 ^ (64'd1 << i) ^ (64'd1 << j), d, ne);
            chk("d4_cw", d, 64'h01D1);
            chk("d4_nerr", 64'(ne), 64'd2);
         end
      for (int i = 0; i < N0; i++)
         for (int j = i + 1; j < N0; j++)
            for (int k = j + 1; k < N0; k++) begin
               check_word(0, "t4", 64'h01D1 ^ (64'd1 << i) ^ (64'd1 << j) ^ (64'd1 << k), d, ne);
               chk("t4_not_orig", 64'(d == 64'h01D1), 64'd0);
            end

      // Back-pressure: result must hold while out_ready is low.
      @(negedge clk);
      iv0 = 1'b1; id0 = 15'h01D9;
      @(negedge clk);
      iv0 = 1'b0;
      guard = 0;
      while (!ov0 && guard < 300) begin @(negedge clk); guard++; end
      chk("bp_reach_valid", 64'(ov0), 64'd1);
      for (int k = 0; k < 20; k++) begin
         iv0 = k[0];
         id0 = 15'($urandom);
         @(negedge clk);
         chk("bp_valid",    64'(ov0), 64'd1);
         chk("bp_data",     64'(od0), 64'h01D1);
         chk("bp_nerr",     64'(ne0), 64'd1);
         chk("bp_in_ready", 64'(ir0), 64'd0);
      end
      iv0 = 1'b0; ordy0 = 1'b1;
      @(negedge clk);
      ordy0 = 1'b0;
      chk("bp_rel_valid",    64'(ov0), 64'd0);
      chk("bp_rel_in_ready", 64'(ir0), 64'd1);
      repeat (40) @(negedge clk);
      chk("bp_no_phantom", 64'(ov0), 64'd0);

      // Asynchronous reset in the middle of the Chien search.
      iv0 = 1'b1; id0 = 15'h41D0;
      @(negedge clk);
      iv0 = 1'b0;
      repeat (N0 + 5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid",    64'(ov0), 64'd0);
      chk("ar_in_ready", 64'(ir0), 64'd1);
      chk("ar_data",     64'(od0), 64'd0);
      chk("ar_nerr",     64'(ne0), 64'd0);
      chk("ar_fail",     64'(f0),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("ar_no_output", 64'(ov0), 64'd0);
      check_word(0, "ar_next", 64'h01D9, d, ne);
      chk("ar_next_cw", d, 64'h01D1);

      // M=5 sweeps on a random codeword.
      cw = clmul(64'($urandom) & ((64'd1 << K1) - 1), g1);
      for (int i = 0; i < N1; i++) begin
         check_word(1, "s5", cw ^ (64'd1 << i), d, ne);
         chk("s5_cw", d, cw);
         chk("s5_nerr", 64'(ne), 64'd1);
      end
      for (int i = 0; i < N1; i++)
         for (int j = i + 1; j < N1; j++) begin
            check_word(1, "d5", cw ^ (64'd1 << i) ^ (64'd1 << j), d, ne);
            chk("d5_cw", d, cw);
         end

      // Random codewords with 0..3 random errors on both decoders.
      for (int t = 0; t < 30; t++) begin
         cw = clmul(64'($urandom) & ((64'd1 << K0) - 1), g0);
         w  = cw ^ rand_err(N0, int'($urandom_range(3, 0)));
         check_word(0, "r4", w, d, ne);
         cw = clmul(64'($urandom) & ((64'd1 << K1) - 1), g1);
         w  = cw ^ rand_err(N1, int'($urandom_range(3, 0)));
         check_word(1, "r5", w, d, ne);
      end

      msg = '0;
      if (msg != '0) chk("unused", msg, 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
